// File: rtl/tmp_sched.sv
// tmp_sched -- round-robin scheduler sharing one TMP timer among N_REQ
// requesters. The winner's tick count is written to the TMP data register.
// A start command and later a clear command are then written to the TMP
// control register. The winner receives a one-cycle done pulse.
//
// Build option: define TMP_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of
// TO_CYC cycles. A timeout forces the clear and pulses err together with done.
// Without the macro, err is tied low and WAIT waits for tmp_done indefinitely.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   req          per-requester level request, held until its done
//   req_count    per-requester tick count, slice i = [i*DW +: DW]
//   gnt          one-hot grant for the whole service (LOAD..RELEASE)
//   done         one-cycle completion pulse to the granted requester
//   err          one-cycle timeout flag, coincident with done
//   busy         high whenever the FSM is not idle
//   tmp_wdata    write data for the TMP registers
//   tmp_wr_data  TMP data-register write strobe
//   tmp_wr_ctrl  TMP control-register write strobe
//   tmp_done     TMP expiry flag, level
module tmp_sched #(
  parameter int N_REQ  = 4,
  parameter int DW     = 32,
  parameter int TO_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_count,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic                busy,
  output logic [DW-1:0]       tmp_wdata,
  output logic                tmp_wr_data,
  output logic                tmp_wr_ctrl,
  input  logic                tmp_done
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("tmp_sched: N_REQ must be in 2..8");
  end
  if (TO_CYC < 1) begin : g_bad_tocyc
    $error("tmp_sched: TO_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CLEAR,
    S_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_cnt;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_scan;
  logic            w_found;
  logic            w_wait_exit;
  logic [N_REQ-1:0] w_onehot;

  // Modulo-N_REQ increment; N_REQ need not be a power of two.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(N_REQ - 1)) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // Round-robin scan starting at r_ptr; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_scan  = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
      w_scan = wrap_inc(w_scan);
    end
  end

`ifdef TMP_SCHED_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_to;
  logic        w_to_hit;

  // The counter is zero in the first WAIT cycle. Hitting TO_CYC-1 therefore
  // means TO_CYC cycles were spent in WAIT.
  assign w_to_hit = (r_wd == 32'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_wd <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + 32'd1;
      end
      // A real expiry in the same cycle as the limit takes precedence.
      if (r_state == S_IDLE) begin
        r_to <= 1'b0;
      end else if (r_state == S_WAIT && !tmp_done && w_to_hit) begin
        r_to <= 1'b1;
      end
    end
  end

  assign w_wait_exit = tmp_done | w_to_hit;
  assign err         = (r_state == S_RELEASE) & r_to;
`else
  assign w_wait_exit = tmp_done;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_idx <= w_win;
        r_cnt <= req_count[w_win*DW +: DW];
        r_ptr <= wrap_inc(w_win);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    tmp_wdata   = '0;
    tmp_wr_data = 1'b0;
    tmp_wr_ctrl = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        tmp_wdata   = r_cnt;
        tmp_wr_data = 1'b1;
        // A zero-tick interval completes without running the timer.
        w_next      = (r_cnt == '0) ? S_RELEASE : S_START;
      end
      S_START: begin
        tmp_wdata   = DW'(1);
        tmp_wr_ctrl = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_exit) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tmp_wdata   = DW'(2);
        tmp_wr_ctrl = 1'b1;
        w_next      = S_RELEASE;
      end
      S_RELEASE: begin
        // The release cycle never re-arbitrates. The next scan happens in IDLE
        // with the pointer already past this requester.
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_onehot = N_REQ'(1) << r_idx;
  assign busy     = (r_state != S_IDLE);
  assign gnt      = busy ? w_onehot : '0;
  assign done     = (r_state == S_RELEASE) ? w_onehot : '0;

endmodule

// File: tb/tb_tmp_sched.sv
// Testbench for tmp_sched. It contains a TMP timer model and a scoreboard of
// expected services. Entries are pushed when requests are driven. They are
// popped and compared on every done pulse.
module tb_tmp_sched;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_count;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            err;
  logic            busy;
  logic [DW-1:0]   tmp_wdata;
  logic            tmp_wr_data;
  logic            tmp_wr_ctrl;
  logic            tmp_done;

  tmp_sched #(.N_REQ(N), .DW(DW), .TO_CYC(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_count   (req_count),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .tmp_wdata   (tmp_wdata),
    .tmp_wr_data (tmp_wr_data),
    .tmp_wr_ctrl (tmp_wr_ctrl),
    .tmp_done    (tmp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    bit err;
    int lat;   // cycles from data write to done; -1 = not checked
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  // TMP model and per-service monitor state
  bit          hang = 1'b0;
  bit          kick = 1'b0;
  bit          kicked = 1'b0;
  bit          tmr_run = 1'b0;
  int          tmr_left = 0;
  int          cyc = 0;
  logic [31:0] m_wdata = '0;
  int          m_load_cyc = 0;
  int          m_nctrl = 0;
  logic [7:0]  m_ctrl_seq = '0;
  int          m_twohot = 0;

  task automatic check_eq(input string tag, input longint got, input longint expv);
    n_chk++;
    if (got == expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int exp_lat(input int cnt);
    return (cnt == 0) ? 1 : cnt + 3;
  endfunction

  task automatic push(input int idx, input int cnt, input bit er, input int lat);
    exp_t x;
    x.idx = idx;
    x.cnt = cnt;
    x.err = er;
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic set_cnt(input int i, input int v);
    req_count[i*DW +: DW] = v;
  endtask

  // Waits for the done count to reach target within a cycle budget.
  // Optionally each requester drops its request when its done is seen.
  task automatic wait_dones(input int target, input int budget, input bit drop);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
      if (drop) req = req & ~done;
    end
    check_eq("done_count", n_done, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      tmp_done = 1'b0;
      tmr_run  = 1'b0;
      kicked   = 1'b0;
    end else begin
      cyc++;
      if (tmr_run) begin
        tmr_left--;
        if (tmr_left <= 0) begin
          tmp_done = 1'b1;
          tmr_run  = 1'b0;
        end
      end
      if (!kick) begin
        kicked = 1'b0;
      end else if (!kicked) begin
        tmp_done = 1'b1;
        kicked   = 1'b1;
      end
      if ($countones(gnt) > 1 || (tmp_wr_data && tmp_wr_ctrl)) m_twohot++;
      if (tmp_wr_data) begin
        m_wdata    = tmp_wdata;
        m_load_cyc = cyc;
        m_nctrl    = 0;
        m_ctrl_seq = '0;
        m_twohot   = 0;
      end
      if (tmp_wr_ctrl) begin
        m_nctrl++;
        m_ctrl_seq = {m_ctrl_seq[3:0], tmp_wdata[3:0]};
        if (tmp_wdata == 32'd1) begin
          tmr_left = int'(m_wdata);
          tmr_run  = !hang && (m_wdata != 0);
        end else if (tmp_wdata == 32'd2) begin
          tmp_done = 1'b0;
          tmr_run  = 1'b0;
        end
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra_done", longint'(done), 0);
        end else begin
          e = sb.pop_front();
          check_eq("done_idx", longint'(done), longint'(1) << e.idx);
          check_eq("gnt_at_done", longint'(gnt), longint'(1) << e.idx);
          check_eq("data_write", longint'(m_wdata), e.cnt);
          check_eq("ctrl_writes", m_nctrl, (e.cnt == 0) ? 0 : 2);
          if (e.cnt != 0) check_eq("ctrl_seq", longint'(m_ctrl_seq), 8'h12);
          check_eq("err_at_done", longint'(err), longint'(e.err));
          check_eq("onehot", m_twohot, 0);
          if (e.lat >= 0) check_eq("latency", cyc - m_load_cyc, e.lat);
        end
        n_done++;
      end
    end
  end

  initial begin
    int tgt;
    rst       = 1'b1;
    req       = '0;
    req_count = '0;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_gnt", longint'(gnt), 0);
    check_eq("rst_done", longint'(done), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_err", longint'(err), 0);
    check_eq("rst_wdata", longint'(tmp_wdata), 0);
    check_eq("rst_wr_data", longint'(tmp_wr_data), 0);
    check_eq("rst_wr_ctrl", longint'(tmp_wr_ctrl), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single request, count 5
    push(0, 5, 1'b0, exp_lat(5));
    set_cnt(0, 5);
    req = 4'b0001;
    tgt = n_done + 1;
    wait_dones(tgt, 100, 1'b1);
    @(negedge clk);
    check_eq("busy_after", longint'(busy), 0);

    // Simultaneous req1/req3 from reset, then ptr at 0 favours req0 over req1
    do_reset();
    push(1, 3, 1'b0, exp_lat(3));
    push(3, 7, 1'b0, exp_lat(7));
    set_cnt(1, 3);
    set_cnt(3, 7);
    req = 4'b1010;
    tgt = n_done + 2;
    wait_dones(tgt, 200, 1'b1);
    push(0, 2, 1'b0, exp_lat(2));
    push(1, 0, 1'b0, exp_lat(0));
    set_cnt(0, 2);
    set_cnt(1, 0);
    req = 4'b0011;
    tgt = n_done + 2;
    wait_dones(tgt, 200, 1'b1);

    // Zero count: no timer run
    push(2, 0, 1'b0, exp_lat(0));
    set_cnt(2, 0);
    req = 4'b0100;
    tgt = n_done + 1;
    wait_dones(tgt, 50, 1'b1);

    // Reset in the middle of WAIT
    set_cnt(1, 50);
    req = 4'b0010;
    repeat (8) @(negedge clk);
    check_eq("busy_in_wait", longint'(busy), 1);
    rst = 1'b0;
    #1;
    check_eq("arst_gnt", longint'(gnt), 0);
    check_eq("arst_busy", longint'(busy), 0);
    check_eq("arst_done", longint'(done), 0);
    check_eq("arst_wdata", longint'(tmp_wdata), 0);
    check_eq("arst_strobes", longint'({tmp_wr_data, tmp_wr_ctrl}), 0);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(0, 4, 1'b0, exp_lat(4));
    push(3, 1, 1'b0, exp_lat(1));
    set_cnt(0, 4);
    set_cnt(3, 1);
    req = 4'b1001;
    tgt = n_done + 2;
    wait_dones(tgt, 200, 1'b1);

    // Continuous req0/req1: strict alternation
    set_cnt(0, 1);
    set_cnt(1, 2);
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 1'b0, exp_lat(1));
      push(1, 2, 1'b0, exp_lat(2));
    end
    req = 4'b0011;
    tgt = n_done + 6;
    wait_dones(tgt, 300, 1'b0);
    req = '0;
    @(negedge clk);

    // Timer that never expires; the requester drops req mid-service
    hang = 1'b1;
    set_cnt(2, 3);
`ifdef TMP_SCHED_TIMEOUT_EN
    push(2, 3, 1'b1, 23);
    req = 4'b0100;
    repeat (5) @(negedge clk);
    req = '0;
    tgt = n_done + 1;
    wait_dones(tgt, 200, 1'b0);
`else
    req = 4'b0100;
    repeat (5) @(negedge clk);
    req = '0;
    tgt = n_done;
    repeat (60) @(negedge clk);
    check_eq("hang_busy", longint'(busy), 1);
    check_eq("hang_gnt", longint'(gnt), 4'b0100);
    check_eq("hang_err", longint'(err), 0);
    check_eq("hang_no_done", n_done, tgt);
    push(2, 3, 1'b0, -1);
    kick = 1'b1;
    tgt = n_done + 1;
    wait_dones(tgt, 50, 1'b0);
    kick = 1'b0;
`endif
    hang = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("busy_end", longint'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tmp_sched.md
Name: tmp_sched

Overview:
- Round-robin scheduler that shares the single TMP timer peripheral among N_REQ requesters (CPU core, DMA, other peripherals).
- Each requester asks for one timed interval with a tick count.
- The block grants one requester at a time and writes the count into the TMP data register.
- It then issues start and clear commands through the TMP control register, waits for TMP expiry, and returns a done pulse to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 32, width of TMP register bus and count values
- TO_CYC, 65535, watchdog limit in clk cycles for WAIT state (used only with TMP_SCHED_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  N_REQ  per-requester interval request, level; held until matching done
- req_count  input  N_REQ*DW  per-requester tick count, slice i = bits [i*DW +: DW]
- gnt  output  N_REQ  one-hot grant, high for the whole service of the winner
- done  output  N_REQ  one-cycle completion pulse to the granted requester
- err  output  1  one-cycle timeout pulse, coincident with done (only with macro; tied 0 otherwise)
- busy  output  1  high whenever state != IDLE
- tmp_wdata  output  DW  write data to TMP registers
- tmp_wr_data  output  1  TMP data-register write strobe
- tmp_wr_ctrl  output  1  TMP control-register write strobe
- tmp_done  input  1  TMP expiry flag, level, valid from start command until clear command

Behaviour:
- Reset (rst=0, any state):
  - FSM to IDLE.
  - RR pointer = 0, latched index = 0, latched count = 0.
  - Watchdog counter = 0.
  - All outputs 0, effective immediately (asynchronous).
- FSM states: IDLE, LOAD, START, WAIT, CLEAR, RELEASE.
- IDLE:
  - If any req bit is 1, pick the first set bit scanning ptr, ptr+1, ... mod N_REQ.
  - Latch winner index and its req_count; set ptr = winner+1 mod N_REQ.
  - Go to LOAD; otherwise stay in IDLE.
- LOAD:
  - tmp_wdata = latched count, tmp_wr_data = 1.
  - If latched count == 0, go to RELEASE (no timer run); else go to START.
- START: tmp_wdata = 1 (start command), tmp_wr_ctrl = 1; go to WAIT.
- WAIT: outputs idle (strobes 0); stay until tmp_done = 1, then go to CLEAR.
- CLEAR: tmp_wdata = 2 (clear command), tmp_wr_ctrl = 1; go to RELEASE.
- RELEASE: done[idx] = 1 for exactly one cycle; go to IDLE.
- Grant and busy:
  - gnt[idx] = 1 in LOAD, START, WAIT, CLEAR and RELEASE; 0 in IDLE.
  - busy follows the same states.
- tmp_wdata = 0 in any state not listed above.
- Latency, nonzero count: req seen in IDLE at edge t → LOAD strobe in cycle t+1, START in t+2, first WAIT in t+3. With tmp_done sampled high at end of WAIT cycle k, CLEAR is k+1, done pulse is k+2.
- Latency, zero count: req at t → LOAD t+1, done t+2.
- Requests and inputs during service:
  - Requests arriving while busy wait; no preemption.
  - req_count changes after the grant are ignored.
  - A requester dropping req mid-service does not abort; its done still pulses.
- Back-to-back requests:
  - The granted requester's req still high in RELEASE does not cause a regrant in that cycle.
  - The next arbitration happens in IDLE one cycle later, with ptr already past it (fairness).
- tmp_done already high on entering WAIT: leave WAIT after one cycle.
- tmp_done while not in WAIT: ignored.
- Only one of tmp_wr_data / tmp_wr_ctrl is ever high in a cycle.

Optional Feature:
- Macro: TMP_SCHED_TIMEOUT_EN.
- When defined:
  - A 32-bit watchdog counts cycles spent in WAIT and clears on entry to WAIT.
  - If it reaches TO_CYC without tmp_done, go to CLEAR (timer cleared as normal).
  - In the following RELEASE, done[idx] and err pulse together.
- When undefined: no watchdog logic, err constant 0, WAIT waits indefinitely.

Test Plan:
- req[0]=1, count=5; model tmp_done high 5 cycles after start → gnt=4'b0001, one data write of 5, ctrl writes 1 then 2, done[0] pulse 2 cycles after tmp_done, busy low afterwards.
- req=4'b1010 simultaneously, counts 3 and 7, after reset → req1 served first, then req3; gnt never two-hot; ptr then 0, so a new req0 beats req1.
- req[2]=1, count=0 → data write of 0, no tmp_wr_ctrl pulse, done[2] two cycles after grant.
- Assert rst=0 during WAIT → all outputs 0 immediately; after release, FSM in IDLE, new req[3] granted normally with ptr=0 scan.
- req[0] and req[1] held high continuously → grants strictly alternate 0,1,0,1; each done pulses exactly once per service.
- With TMP_SCHED_TIMEOUT_EN, TO_CYC=20, tmp_done never asserted → clear command 20 cycles after WAIT entry, then done and err pulse together; without macro the same stimulus stays in WAIT and err stays 0.
